// File: rtl/wires.sv
// Shared memory-port types plus the register layout of the two-port memory arbiter.
package wires;

   typedef struct packed {
      logic        mem_valid;
      logic        mem_instr;
      logic [31:0] mem_addr;
      logic [31:0] mem_wdata;
      logic [3:0]  mem_wstrb;
   } mem_in_type;

   typedef struct packed {
      logic        mem_ready;
      logic [31:0] mem_rdata;
   } mem_out_type;

   typedef enum logic [1:0] {IDLE, IBUSY, DBUSY} arb_state_type;

   // Encoding of the round-robin flag: which port completed the previous access.
   localparam logic LAST_I = 1'b0;
   localparam logic LAST_D = 1'b1;

   typedef struct packed {
      arb_state_type state;
      logic          last;
      mem_in_type    req;
      logic [31:0]   counter;
   } mem_arbiter_reg_type;

   localparam mem_arbiter_reg_type init_mem_arbiter_reg = '{
      state:   IDLE,
      last:    LAST_I,
      req:     '0,
      counter: '0
   };

endpackage

// File: rtl/mem_arbiter.sv
// Shares one native memory port between instruction fetch and load/store with a registered
// round-robin grant and a per-access timeout watchdog.
module mem_arbiter
   import wires::*;
#(
   parameter int unsigned TIMEOUT = 1023
) (
   input  logic        reset,
   input  logic        clock,
   input  mem_in_type  imem_in,
   output mem_out_type imem_out,
   input  mem_in_type  dmem_in,
   output mem_out_type dmem_out,
   output mem_in_type  mem_in,
   input  mem_out_type mem_out,
   output logic        timeout
);

   // Counter saturates at the top of a $clog2(TIMEOUT+1)-bit range; upper bits stay zero.
   localparam int unsigned CntW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [32:0] CntMaxW = (33'd1 << CntW) - 33'd1;
   localparam logic [31:0] CntMax  = CntMaxW[31:0];

   mem_arbiter_reg_type r, rin;
   mem_out_type         resp;
   logic                done;
   logic [31:0]         cnt_inc;

   always_comb begin
      rin      = r;
      imem_out = '0;
      dmem_out = '0;
      mem_in   = '0;
      timeout  = 1'b0;
      resp     = '0;
      done     = 1'b0;
      cnt_inc  = (r.counter == CntMax) ? r.counter : r.counter + 32'd1;

      unique case (r.state)
         IDLE: begin
            if (dmem_in.mem_valid && (!imem_in.mem_valid || r.last == LAST_I)) begin
               rin.state   = DBUSY;
               rin.req     = dmem_in;
               rin.counter = '0;
            end else if (imem_in.mem_valid) begin
               rin.state   = IBUSY;
               rin.req     = imem_in;
               rin.counter = '0;
            end
         end

         IBUSY, DBUSY: begin
            mem_in           = r.req;
            mem_in.mem_valid = 1'b1;
            if (r.state == IBUSY) begin
               mem_in.mem_instr = 1'b1;
               mem_in.mem_wstrb = '0;
               mem_in.mem_wdata = '0;
            end else begin
               mem_in.mem_instr = 1'b0;
            end

            if (mem_out.mem_ready) begin
               resp = mem_out;
               done = 1'b1;
            end else if (TIMEOUT != 0 && cnt_inc == TIMEOUT) begin
               // Abort: release the owner with an empty response.
               resp.mem_ready = 1'b1;
               timeout        = 1'b1;
               done           = 1'b1;
            end else begin
               rin.counter = cnt_inc;
            end

            if (done) begin
               rin.state = IDLE;
               rin.last  = (r.state == DBUSY) ? LAST_D : LAST_I;
            end

            if (r.state == IBUSY) begin
               imem_out = resp;
            end else begin
               dmem_out = resp;
            end
         end

         default: rin = init_mem_arbiter_reg;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r <= init_mem_arbiter_reg;
      end else begin
         r <= rin;
      end
   end

endmodule
